// File: rtl/adc_sequencer.sv
// ADC acquisition sequencer: optional config word to the ADC manager, then periodic triggers.
// Optional feature macro: ADC_SEQ_OVERRUN_CNT_EN enables the missed-slot counter.
module adc_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic                 cfg_en,
    input  logic [23:0]          cfg_word,
    input  logic                 adc_ready,
    output logic                 trigger,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [15:0]          overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CFG      = 3'd1,
        S_CFG_WAIT = 3'd2,
        S_RUN      = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [23:0]          cfg_word_q, cfg_word_d;
    logic [CNT_WIDTH-1:0] phase_q, phase_d;
    logic [1:0]           wait_q, wait_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic                 slot;
    logic                 start_ok;

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    logic [15:0] overrun_q, overrun_d;
`endif

    assign slot     = (state_q == S_RUN) && (phase_q == '0);
    assign start_ok = start && !stop;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        num_d        = num_q;
        cfg_word_d   = cfg_word_q;
        phase_d      = phase_q;
        wait_d       = wait_q;
        stop_pend_d  = stop_pend_q;
        sample_cnt_d = sample_cnt_q;
`ifdef ADC_SEQ_OVERRUN_CNT_EN
        overrun_d    = overrun_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    period_d     = (period < TWO) ? TWO : period;
                    num_d        = num_samples;
                    cfg_word_d   = cfg_word;
                    sample_cnt_d = '0;
`ifdef ADC_SEQ_OVERRUN_CNT_EN
                    overrun_d    = 16'd0;
`endif
                    phase_d      = '0;
                    wait_d       = 2'd0;
                    stop_pend_d  = 1'b0;
                    state_d      = cfg_en ? S_CFG : S_RUN;
                end
            end
            S_CFG: begin
                // tvalid must stay up until accepted, so an abort is only remembered here
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (m_axis_tready) begin
                    wait_d      = 2'd0;
                    stop_pend_d = 1'b0;
                    state_d     = (stop || stop_pend_q) ? S_DRAIN : S_CFG_WAIT;
                end
            end
            S_CFG_WAIT: begin
                if (stop) begin
                    wait_d  = 2'd0;
                    state_d = S_DRAIN;
                end else if (wait_q != 2'd2) begin
                    wait_d = wait_q + 2'd1;
                end else if (adc_ready) begin
                    phase_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                phase_d = (phase_q == period_q - ONE) ? '0 : phase_q + ONE;
                if (slot) begin
                    if (adc_ready) begin
                        sample_cnt_d = sample_cnt_q + ONE;
                        if ((num_q != '0) && (sample_cnt_q + ONE == num_q)) begin
                            wait_d  = 2'd0;
                            state_d = S_DRAIN;
                        end
                    end else begin
`ifdef ADC_SEQ_OVERRUN_CNT_EN
                        if (overrun_q != 16'hFFFF) begin
                            overrun_d = overrun_q + 16'd1;
                        end
`endif
                    end
                end
                if (stop) begin
                    wait_d  = 2'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wait_q != 2'd2) begin
                    wait_d = wait_q + 2'd1;
                end else if (adc_ready) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            num_q        <= '0;
            cfg_word_q   <= 24'd0;
            phase_q      <= '0;
            wait_q       <= 2'd0;
            stop_pend_q  <= 1'b0;
            sample_cnt_q <= '0;
`ifdef ADC_SEQ_OVERRUN_CNT_EN
            overrun_q    <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            num_q        <= num_d;
            cfg_word_q   <= cfg_word_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            stop_pend_q  <= stop_pend_d;
            sample_cnt_q <= sample_cnt_d;
`ifdef ADC_SEQ_OVERRUN_CNT_EN
            overrun_q    <= overrun_d;
`endif
        end
    end

    // Outputs decode directly from state so reset clears them without a clock edge
    assign trigger       = slot && adc_ready;
    assign m_axis_tvalid = (state_q == S_CFG);
    assign m_axis_tdata  = {8'h00, cfg_word_q};
    assign busy          = (state_q == S_CFG) || (state_q == S_CFG_WAIT) ||
                           (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign state         = state_q;
    assign sample_cnt    = sample_cnt_q;

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: one task per scenario, inline comparisons.
module tb_adc_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic [31:0] num_samples;
    logic        cfg_en;
    logic [23:0] cfg_word;
    logic        adc_ready;
    logic        trigger;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        done;
    logic [2:0]  state;
    logic [31:0] sample_cnt;
    logic [15:0] overrun_cnt;

    int errors = 0;
    int checks = 0;

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    localparam logic [15:0] EXP_OVR = 16'd2;
`else
    localparam logic [15:0] EXP_OVR = 16'd0;
`endif

    adc_sequencer #(.CNT_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .stop          (stop),
        .period        (period),
        .num_samples   (num_samples),
        .cfg_en        (cfg_en),
        .cfg_word      (cfg_word),
        .adc_ready     (adc_ready),
        .trigger       (trigger),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .state         (state),
        .sample_cnt    (sample_cnt),
        .overrun_cnt   (overrun_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        start = 0; stop = 0; period = 0; num_samples = 0; cfg_en = 0;
        cfg_word = 0; adc_ready = 1; m_axis_tready = 0;
        repeat (2) step();
        @(negedge aclk);
        checks++;
        if ({state, trigger, m_axis_tvalid, busy, done} !== 7'b000_0000) begin
            errors++;
            $display("FAIL reset_ctl: got state=%0d trig=%b tvalid=%b busy=%b done=%b, want all 0",
                     state, trigger, m_axis_tvalid, busy, done);
        end
        checks++;
        if (sample_cnt !== 32'd0 || overrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got sample=%0d ovr=%0d, want 0 0", sample_cnt, overrun_cnt);
        end
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_basic_run();
        logic [63:0] mask = '0;
        int first_drain = -1;
        int first_done = -1;
        period = 10; num_samples = 3; cfg_en = 0; adc_ready = 1;
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge aclk);
            if (trigger) mask[i] = 1'b1;
            if (state == 3'd4 && first_drain < 0) first_drain = i;
            if (state == 3'd5 && first_done < 0) first_done = i;
            step();
        end
        checks++;
        if (mask !== 64'h0000_0000_0010_0401) begin
            errors++;
            $display("FAIL basic_trig_pos: got mask=%h, want 0000000000100401", mask);
        end
        checks++;
        if (first_drain != 21 || first_done != 24) begin
            errors++;
            $display("FAIL basic_drain_done: got drain=%0d done=%0d, want 21 24", first_drain, first_done);
        end
        @(negedge aclk);
        checks++;
        if (sample_cnt !== 32'd3 || done !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_final: got sample=%0d done=%b busy=%b ovr=%0d, want 3 1 0 0",
                     sample_cnt, done, busy, overrun_cnt);
        end
        step();
    endtask

    task automatic test_cfg_handshake();
        int bad = 0;
        period = 5; num_samples = 1; cfg_en = 1; cfg_word = 24'h800014;
        m_axis_tready = 0; adc_ready = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (state !== 3'd1 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0080_0014 || busy !== 1'b1)
                bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cfg_hold: got %0d bad cycles (tdata=%h tvalid=%b), want 0", bad, m_axis_tdata, m_axis_tvalid);
        end
        m_axis_tready = 1;
        step();
        m_axis_tready = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (state !== 3'd2 || m_axis_tvalid !== 1'b0 || trigger !== 1'b0) bad++;
            step();
        end
        adc_ready = 1;
        @(negedge aclk);
        if (state !== 3'd2) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cfg_wait: got %0d bad cycles, state=%0d, want 0 bad", bad, state);
        end
        step();
        @(negedge aclk);
        checks++;
        if (state !== 3'd3 || trigger !== 1'b1) begin
            errors++;
            $display("FAIL cfg_first_trig: got state=%0d trig=%b, want 3 1", state, trigger);
        end
        step();
        @(negedge aclk);
        checks++;
        if (state !== 3'd4 || sample_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cfg_drain: got state=%0d sample=%0d, want 4 1", state, sample_cnt);
        end
        repeat (4) step();
    endtask

    task automatic test_overrun();
        int trig_cnt = 0;
        int bad = 0;
        bit found = 0;
        period = 4; num_samples = 0; cfg_en = 0; adc_ready = 1;
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            adc_ready = (i == 4 || i == 8) ? 1'b0 : 1'b1;
            @(negedge aclk);
            if (trigger) trig_cnt++;
            if ((i == 4 || i == 8) && trigger !== 1'b0) bad++;
            step();
        end
        adc_ready = 1;
        checks++;
        if (trig_cnt != 2 || bad != 0 || sample_cnt !== 32'd2) begin
            errors++;
            $display("FAIL ovr_slots: got trig=%0d bad=%0d sample=%0d, want 2 0 2", trig_cnt, bad, sample_cnt);
        end
        stop = 1;
        step();
        stop = 0;
        @(negedge aclk);
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL ovr_stop_drain: got state=%0d, want 4", state);
        end
        for (int i = 0; i < 6 && !found; i++) begin
            step();
            @(negedge aclk);
            if (state == 3'd5) found = 1;
        end
        checks++;
        if (!found || overrun_cnt !== EXP_OVR || sample_cnt !== 32'd2) begin
            errors++;
            $display("FAIL ovr_done: got done_seen=%0d ovr=%0d sample=%0d, want 1 %0d 2",
                     found, overrun_cnt, sample_cnt, EXP_OVR);
        end
        step();
    endtask

    task automatic test_stop_in_cfg();
        int bad = 0;
        int trig_seen = 0;
        bit found = 0;
        period = 3; num_samples = 5; cfg_en = 1; cfg_word = 24'h123456;
        m_axis_tready = 0; adc_ready = 1;
        pulse_start();
        stop = 1;
        step();
        stop = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            if (state !== 3'd1 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0012_3456) bad++;
            if (trigger) trig_seen++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stopcfg_hold: got %0d bad cycles, want 0", bad);
        end
        m_axis_tready = 1;
        step();
        m_axis_tready = 0;
        @(negedge aclk);
        checks++;
        if (state !== 3'd4 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL stopcfg_drain: got state=%0d tvalid=%b, want 4 0", state, m_axis_tvalid);
        end
        for (int i = 0; i < 8 && !found; i++) begin
            if (trigger) trig_seen++;
            if (state == 3'd5) found = 1;
            step();
            @(negedge aclk);
        end
        checks++;
        if (!found || trig_seen != 0 || sample_cnt !== 32'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL stopcfg_done: got done_seen=%0d trig=%0d sample=%0d done=%b, want 1 0 0 1",
                     found, trig_seen, sample_cnt, done);
        end
        step();
    endtask

    task automatic test_async_reset();
        int trig_seen = 0;
        int bad = 0;
        period = 8; num_samples = 0; cfg_en = 0; adc_ready = 1;
        pulse_start();
        repeat (3) step();
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || trigger !== 1'b0 || busy !== 1'b0 || sample_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d trig=%b busy=%b sample=%0d, want 0 0 0 0",
                     state, trigger, busy, sample_cnt);
        end
        repeat (2) step();
        aresetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (trigger) trig_seen++;
            if (state !== 3'd0) bad++;
            step();
        end
        checks++;
        if (trig_seen != 0 || bad != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got trig=%0d nonidle=%0d, want 0 0", trig_seen, bad);
        end
    endtask

    task automatic test_min_period();
        logic [63:0] mask;
        for (int p = 1; p >= 0; p--) begin
            mask = '0;
            period = p; num_samples = 4; cfg_en = 0; adc_ready = 1;
            pulse_start();
            for (int i = 0; i < 14; i++) begin
                @(negedge aclk);
                if (trigger) mask[i] = 1'b1;
                step();
            end
            @(negedge aclk);
            checks++;
            if (mask !== 64'h55 || state !== 3'd5 || sample_cnt !== 32'd4) begin
                errors++;
                $display("FAIL min_period_%0d: got mask=%h state=%0d sample=%0d, want 55 5 4",
                         p, mask, state, sample_cnt);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] mask = '0;
        int bad = 0;
        period = 3; num_samples = 2; cfg_en = 0; adc_ready = 1;
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        @(negedge aclk);
        checks++;
        if (state !== 3'd5 || done !== 1'b1 || sample_cnt !== 32'd4) begin
            errors++;
            $display("FAIL start_stop_same: got state=%0d done=%b sample=%0d, want 5 1 4", state, done, sample_cnt);
        end
        step();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            start = (i == 1);
            @(negedge aclk);
            if (trigger) mask[i] = 1'b1;
            if (i == 0 && (done !== 1'b0 || sample_cnt !== 32'd0 || state !== 3'd3)) bad++;
            step();
        end
        start = 0;
        @(negedge aclk);
        checks++;
        if (bad != 0 || mask !== 64'h9 || state !== 3'd5 || sample_cnt !== 32'd2) begin
            errors++;
            $display("FAIL back_to_back: got bad=%0d mask=%h state=%0d sample=%0d, want 0 9 5 2",
                     bad, mask, state, sample_cnt);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_cfg_handshake();
        test_overrun();
        test_stop_in_cfg();
        test_min_period();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, meaning width of period, num_samples and sample_cnt.
REQ-002 SHALL have ports: aclk  in  1  sole clock, all logic on rising edge.
REQ-003 aresetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle acquisition start request; stop  in  1  one-cycle abort request.
REQ-005 period  in  CNT_WIDTH  trigger spacing in aclk cycles; num_samples  in  CNT_WIDTH  triggers per run, 0 = continuous.
REQ-006 cfg_en  in  1  send cfg_word before the run; cfg_word  in  24  ADC register-access word.
REQ-007 adc_ready  in  1  ADC manager idle indication; trigger  out  1  conversion trigger pulse to the ADC manager.
REQ-008 m_axis_tdata  out  32  register word to the ADC manager; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-009 busy  out  1; done  out  1; state  out  3; sample_cnt  out  CNT_WIDTH  triggers issued; overrun_cnt  out  16  missed trigger slots.

Function
REQ-010 States SHALL be IDLE=0, CFG=1, CFG_WAIT=2, RUN=3, DRAIN=4, DONE=5, exported on state.
REQ-011 start in IDLE or DONE SHALL latch period, num_samples, cfg_en, cfg_word, clear sample_cnt, overrun_cnt, done, and go to CFG if cfg_en else RUN.
REQ-012 start in CFG, CFG_WAIT, RUN or DRAIN SHALL be ignored.
REQ-013 start and stop in the same cycle in IDLE/DONE: stop wins, state unchanged.
REQ-014 A latched period below 2 SHALL be treated as 2.
REQ-015 CFG: m_axis_tvalid=1, m_axis_tdata={8'h00, cfg_word}, held stable until handshake; handshake -> CFG_WAIT.
REQ-016 CFG_WAIT and DRAIN: adc_ready ignored for the first 2 cycles after entry, then exit on the first cycle adc_ready=1 (CFG_WAIT -> RUN, DRAIN -> DONE).
REQ-017 RUN: phase counter runs 0..period-1 and wraps; a trigger slot occurs at phase 0, the first one in the first RUN cycle.
REQ-018 At a slot with adc_ready=1: trigger=1 for exactly that cycle and sample_cnt increments by 1.
REQ-019 At a slot with adc_ready=0: trigger stays 0 and overrun_cnt increments, saturating at 16'hFFFF.
REQ-020 trigger SHALL be 0 in every non-slot cycle and every state other than RUN.
REQ-021 With num_samples != 0, the cycle after the trigger that makes sample_cnt == num_samples SHALL be DRAIN.
REQ-022 With num_samples == 0, RUN continues until stop; sample_cnt wraps modulo 2^CNT_WIDTH.
REQ-023 stop in CFG SHALL be deferred until the handshake, then go to DRAIN; m_axis_tvalid is never withdrawn before the handshake.
REQ-024 stop in CFG_WAIT or RUN SHALL go to DRAIN next cycle; stop in DRAIN is ignored.
REQ-025 DONE: done=1 until the next accepted start or reset.
REQ-026 busy=1 in CFG, CFG_WAIT, RUN and DRAIN, else 0.
REQ-027 sample_cnt and overrun_cnt SHALL hold their values in IDLE and DONE.

Reset
REQ-028 aresetn low SHALL force state=IDLE immediately, without waiting for a clock edge.
REQ-029 aresetn low SHALL drive trigger, m_axis_tvalid, busy and done to 0 and all counters and latched configuration to 0.
REQ-030 Reset mid-run SHALL abandon any pending handshake; no trigger SHALL follow reset release until a new start.

Configuration
REQ-031 Macro ADC_SEQ_OVERRUN_CNT_EN defined: overrun_cnt SHALL behave per REQ-019.
REQ-032 Macro ADC_SEQ_OVERRUN_CNT_EN undefined: overrun_cnt SHALL be constant 0, no counter logic, and missed slots are skipped silently.

Verification
REQ-033 period=10, num_samples=3, cfg_en=0, adc_ready=1: start -> trigger at RUN cycles 0, 10, 20; sample_cnt=3; DRAIN; done=1 with overrun_cnt=0.
REQ-034 cfg_en=1, cfg_word=24'h800014, m_axis_tready low 5 cycles: tdata=32'h00800014 held stable; after handshake, adc_ready low 4 cycles then high -> RUN, first trigger in the first RUN cycle.
REQ-035 period=4, num_samples=0, adc_ready low at 2nd and 3rd slots: overrun_cnt=2, no trigger in those slots; stop -> DRAIN, then DONE.
REQ-036 stop in CFG before tready: tvalid stays 1 until handshake, then DRAIN, then DONE, with no trigger ever issued.
REQ-037 aresetn asserted mid-RUN at phase 3 of period 8: state=0 and trigger=0 immediately; after release, no trigger without a new start.
REQ-038 period=1 and period=0, num_samples=4: trigger spacing is 2 cycles.
